vmicro16_wb_arbiter: RTL and testbench

Round-robin Wishbone arbiter that shares one slave-side bus between `N_MASTERS` vmicro16 cores in the multi-core SoC. Each core's master port (cyc/stb/we/addr/data/ack) connects on the master side, and the SoC peripheral/register interconnect connects on the slave side. A grant is held for the whole `cyc` cycle of the winning master. A watchdog aborts a transaction that never receives `ack`.

---
 rtl/vmicro16_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_vmicro16_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmicro16_wb_arbiter.sv
// Round-robin Wishbone arbiter: N vmicro16 masters onto one slave bus, grant held for a whole cyc tenure.
// One cycle arbitration latency, one idle cycle between tenures; masters wait (never preempted), watchdog aborts stuck strobes.
module vmicro16_wb_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_MASTERS-1:0]    m_cyc_i,
  input  logic [N_MASTERS-1:0]    m_stb_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [N_MASTERS*AW-1:0] m_addr_i,
  input  logic [N_MASTERS*DW-1:0] m_data_i,
  output logic [DW-1:0]           m_data_o,
  output logic [N_MASTERS-1:0]    m_ack_o,
  output logic [N_MASTERS-1:0]    m_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_addr_o,
  output logic [DW-1:0]           s_data_o,
  input  logic [DW-1:0]           s_data_i,
  input  logic                    s_ack_i,
  output logic [N_MASTERS-1:0]    grant_o,
  output logic                    busy_o
);

  localparam int LW = $clog2(N_MASTERS);
  localparam logic [15:0] TLIM = 16'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_GRANTED = 1'b1;

  logic [N_MASTERS-1:0] grant, grant_nx, err, err_nx;
  logic [LW-1:0]        last, last_nx, gidx, widx, cand;
  logic [15:0]          tcnt, tcnt_nx;
  logic [0:0]           state;
  logic                 found, stall, tmo;

  // The state is implied by the one-hot grant; no separate state register.
  assign state = (|grant) ? S_GRANTED : S_IDLE;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_MASTERS; i++)
      if (grant[i]) gidx = LW'(i);
  end

  always_comb begin
    widx  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = LW'((int'(last) + k) % N_MASTERS);
      if (!found && m_cyc_i[cand]) begin
        widx  = cand;
        found = 1'b1;
      end
    end
  end

  assign busy_o   = |grant;
  assign grant_o  = grant;
  assign m_err_o  = err;
  assign m_data_o = s_data_i;
  assign s_cyc_o  = busy_o & m_cyc_i[gidx];
  assign s_stb_o  = busy_o & m_stb_i[gidx];
  assign s_we_o   = busy_o & m_we_i[gidx];
  assign s_addr_o = busy_o ? m_addr_i[gidx*AW +: AW] : '0;
  assign s_data_o = busy_o ? m_data_i[gidx*DW +: DW] : '0;
  assign m_ack_o  = grant & {N_MASTERS{s_ack_i & s_stb_o}};

  // An ack in the limit cycle suppresses the abort.
  assign stall = s_stb_o & ~s_ack_i;
  assign tmo   = (TIMEOUT != 0) && (tcnt == TLIM) && stall;

  always_comb begin
    grant_nx = grant;
    last_nx  = last;
    tcnt_nx  = tcnt;
    err_nx   = '0;
    case (state)
      S_IDLE: begin
        if (found) begin
          grant_nx       = '0;
          grant_nx[widx] = 1'b1;
          tcnt_nx        = '0;
        end
      end
      S_GRANTED: begin
        if (!m_cyc_i[gidx]) begin
          grant_nx = '0;
          last_nx  = gidx;
        end else if (tmo) begin
          err_nx   = grant;
          grant_nx = '0;
          last_nx  = gidx;
        end else if (stall) begin
          tcnt_nx = (tcnt == 16'hFFFF) ? tcnt : tcnt + 16'd1;
        end else begin
          tcnt_nx = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant <= '0;
      last  <= LW'(N_MASTERS - 1);
      tcnt  <= '0;
      err   <= '0;
    end else begin
      grant <= grant_nx;
      last  <= last_nx;
      tcnt  <= tcnt_nx;
      err   <= err_nx;
    end
  end

endmodule

// File: tb/tb_vmicro16_wb_arbiter.sv
// Bench for vmicro16_wb_arbiter: directed vectors, corner sequences, then random traffic against a tenure-level model.
module tb_vmicro16_wb_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0]    cyc, stb, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdat;
  logic [DW-1:0]   m_data_o, s_data_o, s_data_i;
  logic [N-1:0]    m_ack_o, m_err_o, grant_o;
  logic            s_cyc_o, s_stb_o, s_we_o, s_ack_i, busy_o;
  logic [AW-1:0]   s_addr_o;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vmicro16_wb_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_addr_i(addr), .m_data_i(wdat),
    .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [3:0]  cyc;
    logic [3:0]  stb;
    logic        ack;
    logic [3:0]  g;
    logic        ss;
    logic        sw;
    logic [15:0] sa;
    logic [15:0] sd;
    logic [3:0]  ma;
    logic        busy;
  } vec_t;
  vec_t tbl [17];

  // Tenure-level reference: who owns the bus, who went last, how long the strobe has stalled.
  int own, lst, stl;
  logic [N-1:0] perr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fixed_bus();
    addr = {16'h0100, 16'h00C0, 16'h0080, 16'h0040};
    wdat = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    we   = 4'b0101;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc = '0;
    stb = '0;
    s_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {16'h0, grant_o, busy_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, m_ack_o, m_err_o}, 64'h0);
  endtask

  task automatic model_reset();
    own = -1;
    lst = N - 1;
    stl = 0;
    perr = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] ep;
    ep = '0;
    if (own < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (own < 0 && cyc[(lst + k) % N]) begin
          own = (lst + k) % N;
          stl = 0;
        end
      end
    end else if (!cyc[own]) begin
      lst = own;
      own = -1;
    end else if (stb[own] && !s_ack_i) begin
      if (TO != 0 && stl + 1 == TO) begin
        ep = oh(own);
        lst = own;
        own = -1;
      end else if (stl < 65535) begin
        stl++;
      end
    end else begin
      stl = 0;
    end
    perr = ep;
  endtask

  task automatic run_table();
    tbl[0]  = '{4'h3, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0};
    tbl[1]  = '{4'h3, 4'h3, 1'b0, 4'h1, 1'b1, 1'b1, 16'h0040, 16'h1234, 4'h0, 1'b1};
    tbl[2]  = '{4'h3, 4'h3, 1'b1, 4'h1, 1'b1, 1'b1, 16'h0040, 16'h1234, 4'h1, 1'b1};
    tbl[3]  = '{4'h2, 4'h2, 1'b0, 4'h1, 1'b0, 1'b1, 16'h0040, 16'h1234, 4'h0, 1'b1};
    tbl[4]  = '{4'h2, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0};
    tbl[5]  = '{4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b0, 16'h0080, 16'h5678, 4'h0, 1'b1};
    tbl[6]  = '{4'h2, 4'h2, 1'b1, 4'h2, 1'b1, 1'b0, 16'h0080, 16'h5678, 4'h2, 1'b1};
    tbl[7]  = '{4'h0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 16'h0080, 16'h5678, 4'h0, 1'b1};
    tbl[8]  = '{4'h3, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0};
    tbl[9]  = '{4'h3, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 16'h0040, 16'h1234, 4'h0, 1'b1};
    tbl[10] = '{4'h3, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 16'h0040, 16'h1234, 4'h0, 1'b1};
    tbl[11] = '{4'h3, 4'h1, 1'b1, 4'h1, 1'b1, 1'b1, 16'h0040, 16'h1234, 4'h1, 1'b1};
    tbl[12] = '{4'h2, 4'h0, 1'b0, 4'h1, 1'b0, 1'b1, 16'h0040, 16'h1234, 4'h0, 1'b1};
    tbl[13] = '{4'h2, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0};
    tbl[14] = '{4'h2, 4'h2, 1'b1, 4'h2, 1'b1, 1'b0, 16'h0080, 16'h5678, 4'h2, 1'b1};
    tbl[15] = '{4'h0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 16'h0080, 16'h5678, 4'h0, 1'b1};
    tbl[16] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      cyc = tbl[i].cyc;
      stb = tbl[i].stb;
      s_ack_i = tbl[i].ack;
      #1;
      chk($sformatf("vec%0d", i),
          {grant_o, busy_o, s_stb_o, s_we_o, s_addr_o, s_data_o, m_ack_o, m_err_o},
          {tbl[i].g, tbl[i].busy, tbl[i].ss, tbl[i].sw, tbl[i].sa, tbl[i].sd, tbl[i].ma, 4'h0});
    end
  endtask

  task automatic run_timeouts();
    cyc = 4'h2; stb = 4'h2; s_ack_i = 1'b0;
    step();
    chk("to_grant", grant_o, 4'h2);
    cyc = 4'h3; stb = 4'h3;
    for (int j = 1; j < TO; j++) begin
      step();
      chk("to_wait", {m_err_o, grant_o}, {4'h0, 4'h2});
    end
    step();
    chk("to_err", {m_err_o, grant_o, busy_o}, {4'h2, 4'h0, 1'b0});
    step();
    chk("to_next", {m_err_o, grant_o}, {4'h0, 4'h1});
    cyc = 4'h1; stb = 4'h1;
    for (int j = 1; j < TO; j++) begin
      step();
      chk("al_wait", m_err_o, 4'h0);
    end
    s_ack_i = 1'b1;
    #1;
    chk("al_ack", m_ack_o, 4'h1);
    step();
    chk("al_noerr", {m_err_o, grant_o}, {4'h0, 4'h1});
    s_ack_i = 1'b0;
    for (int j = 1; j < TO; j++) begin
      step();
      chk("al_recount", m_err_o, 4'h0);
    end
    step();
    chk("al_err", {m_err_o, grant_o}, {4'h1, 4'h0});
    cyc = '0; stb = '0;
    step();
  endtask

  task automatic run_fairness();
    int hold;
    int k;
    logic [3:0] prev;
    hold = -1; k = 0; prev = '0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      cyc = '1;
      if (hold >= 0) cyc[hold] = 1'b0;
      stb = cyc;
      s_ack_i = 1'b1;
      #1;
      chk("fair_ack_owner", m_ack_o & ~grant_o, 4'h0);
      if (grant_o != 4'h0 && grant_o != prev) begin
        chk("fair_order", grant_o, oh(k % N));
        k++;
      end
      if (m_ack_o != 4'h0) begin
        for (int i = 0; i < N; i++) if (m_ack_o[i]) hold = i;
      end else if (grant_o == 4'h0) begin
        hold = -1;
      end
      prev = grant_o;
    end
    chk("fair_tenures", k >= 8, 1);
  endtask

  task automatic run_reset_mid();
    do_reset();
    cyc = 4'h1; stb = 4'h1;
    step();
    chk("rst_pre", grant_o, 4'h1);
    s_ack_i = 1'b1;
    #2 reset = 1'b0;
    #1 chk_zero("rst_async");
    cyc = 4'h3; stb = 4'h3; s_ack_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("rst_first", grant_o, 4'h1);
  endtask

  task automatic run_random();
    int ackdiv;
    logic [N-1:0] eg, ema;
    logic es_cyc, es_stb, es_we;
    logic [AW-1:0] esa;
    logic [DW-1:0] esd;
    do_reset();
    model_reset();
    for (int c = 0; c < 900; c++) begin
      ackdiv = (c < 300) ? 2 : (c < 600) ? 6 : 24;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) cyc[i] = ~cyc[i];
        if ($urandom_range(3) == 0) stb[i] = ~stb[i];
        we[i] = 1'($urandom_range(1));
      end
      addr = {$urandom, $urandom};
      wdat = {$urandom, $urandom};
      s_data_i = 16'($urandom);
      s_ack_i = ($urandom_range(ackdiv - 1) == 0);
      #1;
      eg = oh(own);
      es_cyc = 1'b0; es_stb = 1'b0; es_we = 1'b0; esa = '0; esd = '0; ema = '0;
      if (own >= 0) begin
        es_cyc = cyc[own];
        es_stb = stb[own];
        es_we  = we[own];
        esa    = addr[own*AW +: AW];
        esd    = wdat[own*DW +: DW];
        if (stb[own] && s_ack_i) ema = eg;
      end
      chk("rnd_grant", {grant_o, busy_o}, {eg, own >= 0});
      chk("rnd_slave", {s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o}, {es_cyc, es_stb, es_we, esa, esd});
      chk("rnd_resp", {m_ack_o, m_err_o, m_data_o}, {ema, perr, s_data_i});
      @(posedge clk);
      model_step();
    end
  endtask

  initial begin
    cyc = '0; stb = '0; s_ack_i = 1'b0; s_data_i = 16'hA5A5;
    fixed_bus();
    #1 chk_zero("reset_state");
    do_reset();
    run_table();
    run_timeouts();
    run_fairness();
    run_reset_mid();
    run_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
